// File: rtl/pixel_stream_source.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_source
// Purpose  : Reads a stored frame from a synchronous-read frame RAM in raster
//            order and emits it as a valid/ready pixel stream with sof/eol/eof
//            frame markers.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock
//   rstn       in   asynchronous active-low reset
//   start      in   begin one frame transfer (sampled only in IDLE)
//   mem_rd_en  out  frame RAM read strobe
//   mem_addr   out  frame RAM address, row*IMG_W+col
//   mem_rdata  in   RAM read data, valid one cycle after mem_rd_en
//   px_out     out  pixel data (FIFO head)
//   valid_out  out  px_out valid
//   ready_in   in   downstream accept
//   sof        out  current pixel is row 0, col 0
//   eol        out  current pixel is last column of its row
//   eof        out  current pixel is last pixel of the frame
//   busy       out  frame transfer in progress
//   done       out  one-cycle pulse after the eof pixel is accepted
// Build option
//   STREAM_PAD_EN : emit a zero-bordered (IMG_W+2) x (IMG_H+2) frame; border
//                   pixels are synthesised without RAM reads.
// ============================================================================
module pixel_stream_source #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  px_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

`ifdef STREAM_PAD_EN
  localparam int OUT_W = IMG_W + 2;
  localparam int OUT_H = IMG_H + 2;
`else
  localparam int OUT_W = IMG_W;
  localparam int OUT_H = IMG_H;
`endif
  localparam int CW = $clog2(OUT_W + 1);
  localparam int RW = $clog2(OUT_H + 1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(OUT_W - 1);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W*IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] rd_addr_q;
  logic              pend_q;      // one RAM read (or synthetic pixel) in flight
  logic              pend_pad_q;  // in-flight entry is a synthetic zero
  logic [PIX_W-1:0]  fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;
  logic [CW-1:0]     out_col_q;
  logic [RW-1:0]     out_row_q;
  logic              done_q;

  logic       pop, push, issue, last_issue, border, last_pos, credit_ok;
  logic [2:0] level, limit;

  assign valid_out = (count_q != 2'd0);
  assign px_out    = fifo_q[rd_ptr_q];
  assign pop       = valid_out && ready_in;
  assign push      = pend_q;

  // Issue only when the entry is guaranteed a FIFO slot on arrival:
  // held + in-flight - leaving-this-cycle < 2, written without subtraction.
  assign level     = {1'b0, count_q} + {2'b00, pend_q};
  assign limit     = 3'd2 + {2'b00, pop};
  assign credit_ok = (level < limit);

  assign issue      = (state_q == S_FETCH) && credit_ok;
  assign last_issue = issue && last_pos;
  assign mem_rd_en  = issue && !border;
  assign mem_addr   = rd_addr_q;

`ifdef STREAM_PAD_EN
  // Fetch-side position over the padded frame decides read vs synthetic zero.
  logic [CW-1:0] f_col_q;
  logic [RW-1:0] f_row_q;

  assign border   = (f_col_q == '0) || (f_col_q == LAST_COL) ||
                    (f_row_q == '0) || (f_row_q == LAST_ROW);
  assign last_pos = (f_col_q == LAST_COL) && (f_row_q == LAST_ROW);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      f_col_q <= '0;
      f_row_q <= '0;
    end else if (issue) begin
      if (f_col_q == LAST_COL) begin
        f_col_q <= '0;
        f_row_q <= (f_row_q == LAST_ROW) ? '0 : f_row_q + RW'(1);
      end else begin
        f_col_q <= f_col_q + CW'(1);
      end
    end
  end
`else
  assign border   = 1'b0;
  assign last_pos = (rd_addr_q == LAST_ADDR);
`endif

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)      state_d = S_FETCH;
      S_FETCH: if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (eof && pop) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      pend_q     <= 1'b0;
      pend_pad_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= issue;
      pend_pad_q <= issue && border;
      done_q     <= (state_q == S_DRAIN) && eof && pop;
      if (mem_rd_en)
        rd_addr_q <= (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);
    end
  end

  // 2-entry output FIFO; arriving data is captured the cycle after the read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= pend_pad_q ? '0 : mem_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop)
        rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Output-side position, advanced on each accepted pixel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_col_q <= '0;
      out_row_q <= '0;
    end else if (pop) begin
      if (out_col_q == LAST_COL) begin
        out_col_q <= '0;
        out_row_q <= (out_row_q == LAST_ROW) ? '0 : out_row_q + RW'(1);
      end else begin
        out_col_q <= out_col_q + CW'(1);
      end
    end
  end

  assign sof  = valid_out && (out_col_q == '0) && (out_row_q == '0);
  assign eol  = valid_out && (out_col_q == LAST_COL);
  assign eof  = eol && (out_row_q == LAST_ROW);
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_stream_source
// Purpose  : Directed self-checking bench for pixel_stream_source with a
//            4x3 frame held in a synchronous-read RAM model (mem[i] = i+1).
// Revision : 1.0  initial release
// ============================================================================
module tb_pixel_stream_source;
  localparam int PIX_W  = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int ADDR_W = $clog2(IMG_W*IMG_H);
`ifdef STREAM_PAD_EN
  localparam int OW = IMG_W + 2;
  localparam int OH = IMG_H + 2;
`else
  localparam int OW = IMG_W;
  localparam int OH = IMG_H;
`endif
  localparam int TOTAL = OW*OH;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;
  logic [PIX_W-1:0]  px_out;
  logic              valid_out;
  logic              ready_in;
  logic              sof, eol, eof, busy, done;

  logic [PIX_W-1:0]  ram [16];
  logic [4:0]        pat = 5'b01001;  // ready per cycle, index 0 first: 1,0,0,1,0

  int n_cmp = 0;
  int n_err = 0;

  pixel_stream_source #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .px_out    (px_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (mem_rd_en) mem_rdata <= ram[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_px(input int k);
    int r, c;
    r = k / OW;
    c = k % OW;
`ifdef STREAM_PAD_EN
    if (r == 0 || r == OH-1 || c == 0 || c == OW-1) return 0;
    return (r-1)*IMG_W + c;
`else
    return k + 1;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rd_en"}, mem_rd_en, 0);
    check_eq({tag, "_addr"},  mem_addr,  0);
    check_eq({tag, "_px"},    px_out,    0);
    check_eq({tag, "_valid"}, valid_out, 0);
    check_eq({tag, "_sof"},   sof,       0);
    check_eq({tag, "_eol"},   eol,       0);
    check_eq({tag, "_eof"},   eof,       0);
    check_eq({tag, "_busy"},  busy,      0);
    check_eq({tag, "_done"},  done,      0);
  endtask

  // Called at a negedge; the following posedge samples start.
  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs from the negedge of cycle T+1 until done is seen (returns at that
  // negedge), or returns right after abort_at pixels have been accepted.
  task automatic run_frame(input int mode, input int restart_at, input int abort_at);
    int k, cyc, issued, first_cyc, last_cyc;
    logic prev_stall, hs, eof_hs;
    logic [PIX_W-1:0] prev_px;
    bit fin;
    k = 0; cyc = 1; issued = 0; first_cyc = -1; last_cyc = -1;
    prev_stall = 1'b0; prev_px = '0; eof_hs = 1'b0; fin = 1'b0;
    while (!fin && cyc < 400) begin
      if (eof_hs) begin
        check_eq("done_pulse", done, 1);
        check_eq("busy_at_done", busy, 0);
        fin = 1'b1;
      end else begin
        ready_in = (mode == 0) ? 1'b1 : pat[(cyc-1) % 5];
        start    = (cyc == restart_at);
        #1;
        check_eq("busy", busy, 1);
        check_eq("done_early", done, 0);
        if (prev_stall) check_eq("stall_hold", px_out, prev_px);
        if (valid_out) begin
          if (first_cyc < 0) begin
            first_cyc = cyc;
            check_eq("first_valid_cyc", cyc, 3);
          end
          check_eq("sof", sof, (k == 0));
          check_eq("eol", eol, ((k % OW) == OW-1));
          check_eq("eof", eof, (k == TOTAL-1));
        end else begin
          check_eq("idle_markers", {sof, eol, eof}, 0);
        end
        hs = valid_out && ready_in;
        if (mem_rd_en) begin
          check_eq("rd_addr", mem_addr, issued);
          check_eq("credit", ((issued - k - int'(hs)) < 2), 1);
          issued++;
        end
        if (hs) begin
          check_eq("px", px_out, exp_px(k));
          last_cyc = cyc;
          eof_hs   = (k == TOTAL-1);
          k++;
        end
        prev_stall = valid_out && !ready_in;
        prev_px    = px_out;
        if (abort_at > 0 && k == abort_at) return;
        @(negedge clk);
        cyc++;
      end
    end
    check_eq("pixel_count", k, TOTAL);
    if (mode == 0) check_eq("throughput", last_cyc - first_cyc, TOTAL-1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = PIX_W'(i + 1);
    rstn = 1'b0; start = 1'b0; ready_in = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Full-rate frame
    start_pulse();
    run_frame(0, 0, 0);
    @(negedge clk);
    check_eq("done_once", done, 0);
    check_eq("busy_after", busy, 0);
    check_eq("valid_after", valid_out, 0);

    // Back-pressure pattern 1,0,0,1,0
    start_pulse();
    run_frame(1, 0, 0);

    // start re-pulsed mid-frame must be ignored
    @(negedge clk);
    start_pulse();
    run_frame(0, 4, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("no_rerun_valid", valid_out, 0);
      check_eq("no_rerun_busy", busy, 0);
      check_eq("no_rerun_done", done, 0);
    end

    // Asynchronous reset after 5 accepted pixels, then replay
    start_pulse();
    run_frame(0, 0, 5);
    rstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    start_pulse();
    run_frame(0, 0, 0);

    // Back-to-back: start in the cycle done is high
    start_pulse();
    run_frame(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
